// File: rtl/duty_soft_start.sv
// Slew-rate-limited duty generator: synchronises switch inputs and ramps the
// PWM duty toward a clamped target by at most one LSB per prescaler tick.
module duty_soft_start #(
    parameter int DUTY_W   = 8,
    parameter int STEP_DIV = 50000,
    parameter int MAX_DUTY = 230
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [DUTY_W-1:0] i_target,
    output logic [DUTY_W-1:0] o_duty,
    output logic              o_en,
    output logic              o_ramping,
    output logic              o_done
);

    localparam int CNT_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [DUTY_W-1:0] MAX_D   = DUTY_W'(MAX_DUTY);
    localparam logic [CNT_W-1:0]  CNT_TOP = CNT_W'(STEP_DIV - 1);

    typedef enum logic [1:0] {
        IDLE,
        RAMP_UP,
        HOLD,
        RAMP_DOWN
    } state_t;

    state_t state, state_n;

    logic              en_m, en_s;
    logic [DUTY_W-1:0] tgt_m, tgt_s;
    logic [DUTY_W-1:0] tgt_c, tgt_c_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic              tick;
    logic [DUTY_W-1:0] duty_n;
    logic              en_n, ramp_n, done_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_m  <= 1'b0;
            en_s  <= 1'b0;
            tgt_m <= '0;
            tgt_s <= '0;
        end else begin
            en_m  <= enable;
            en_s  <= en_m;
            tgt_m <= i_target;
            tgt_s <= tgt_m;
        end
    end

    assign tgt_c   = (tgt_s > MAX_D) ? MAX_D : tgt_s;
    // Target as it will be seen next cycle, so status flags can be registered.
    assign tgt_c_n = (tgt_m > MAX_D) ? MAX_D : tgt_m;
    assign tick    = (cnt == CNT_TOP);

    always_comb begin
        state_n = state;
        duty_n  = o_duty;
        unique case (state)
            IDLE: begin
                duty_n = '0;
                if (en_s) state_n = RAMP_UP;
            end
            RAMP_UP: begin
                if (tick && (o_duty < tgt_c)) duty_n = o_duty + DUTY_W'(1);
                if (!en_s)                    state_n = RAMP_DOWN;
                else if (o_duty >= tgt_c)     state_n = HOLD;
            end
            HOLD: begin
                if (tick) begin
                    if (o_duty < tgt_c)      duty_n = o_duty + DUTY_W'(1);
                    else if (o_duty > tgt_c) duty_n = o_duty - DUTY_W'(1);
                end
                if (!en_s) state_n = RAMP_DOWN;
            end
            RAMP_DOWN: begin
                if (tick && (o_duty != '0)) duty_n = o_duty - DUTY_W'(1);
                if (en_s)                   state_n = RAMP_UP;
                else if (o_duty == '0)      state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
                duty_n  = '0;
            end
        endcase
    end

    always_comb begin
        if (state == IDLE && state_n == RAMP_UP) cnt_n = '0;
        else if (tick)                           cnt_n = '0;
        else                                     cnt_n = cnt + CNT_W'(1);
    end

    always_comb begin
        en_n   = (state_n != IDLE);
        done_n = (state_n == HOLD) && (duty_n == tgt_c_n);
        ramp_n = (state_n == RAMP_UP) || (state_n == RAMP_DOWN) ||
                 ((state_n == HOLD) && (duty_n != tgt_c_n));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            o_duty    <= '0;
            o_en      <= 1'b0;
            o_ramping <= 1'b0;
            o_done    <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            o_duty    <= duty_n;
            o_en      <= en_n;
            o_ramping <= ramp_n;
            o_done    <= done_n;
        end
    end

endmodule

// File: tb/tb_duty_soft_start.sv
// Scoreboard bench for duty_soft_start: a behavioural model predicts each
// cycle's outputs into a queue, and a negedge monitor compares them.
module tb_duty_soft_start;

    localparam int DW = 8;
    localparam int SD = 4;
    localparam int MX = 230;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable = 1'b0;
    logic [DW-1:0] i_target = '0;
    logic [DW-1:0] o_duty;
    logic          o_en, o_ramping, o_done;

    duty_soft_start #(.DUTY_W(DW), .STEP_DIV(SD), .MAX_DUTY(MX)) dut (
        .clk(clk), .rst(rst), .enable(enable), .i_target(i_target),
        .o_duty(o_duty), .o_en(o_en), .o_ramping(o_ramping), .o_done(o_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int    duty;
        bit    en;
        bit    ramp;
        bit    done;
        string tag;
    } exp_t;

    exp_t  sb[$];
    int    vectors = 0;
    int    miscompares = 0;
    int    cycle = 0;
    string phase_name = "reset";

    // Reference model: mode names, duty as an integer, step phase counted
    // in clocks since the ramp was launched from rest.
    string m_mode;
    int    m_duty, m_phase;
    bit    en_d1, en_d2;
    int    tgt_d1, tgt_d2;

    function automatic int clampt(input int t);
        return (t > MX) ? MX : t;
    endfunction

    task automatic model_reset();
        m_mode = "IDLE"; m_duty = 0; m_phase = 0;
        en_d1 = 0; en_d2 = 0; tgt_d1 = 0; tgt_d2 = 0;
    endtask

    task automatic model_edge();
        int    tc, nd, np;
        bit    es, tick;
        string nm;
        tc   = clampt(tgt_d2);
        es   = en_d2;
        tick = (m_phase == SD - 1);
        nd   = m_duty;
        nm   = m_mode;
        np   = (m_phase + 1) % SD;
        if (m_mode == "IDLE") begin
            nd = 0;
            if (es) begin nm = "UP"; np = 0; end
        end else if (m_mode == "UP") begin
            if (tick && m_duty < tc) nd = m_duty + 1;
            if (!es) nm = "DOWN";
            else if (m_duty >= tc) nm = "HOLD";
        end else if (m_mode == "HOLD") begin
            if (tick) nd = m_duty + ((tc > m_duty) ? 1 : (tc < m_duty) ? -1 : 0);
            if (!es) nm = "DOWN";
        end else begin
            if (tick && m_duty > 0) nd = m_duty - 1;
            if (es) nm = "UP";
            else if (m_duty == 0) nm = "IDLE";
        end
        m_duty = nd; m_mode = nm; m_phase = np;
        en_d2 = en_d1; en_d1 = enable;
        tgt_d2 = tgt_d1; tgt_d1 = int'(i_target);
    endtask

    task automatic push_expected();
        exp_t e;
        int   tc;
        tc     = clampt(tgt_d2);
        e.duty = m_duty;
        e.en   = (m_mode != "IDLE");
        e.ramp = (m_mode == "UP") || (m_mode == "DOWN") || (m_mode == "HOLD" && m_duty != tc);
        e.done = (m_mode == "HOLD") && (m_duty == tc);
        e.tag  = phase_name;
        sb.push_back(e);
    endtask

    task automatic step(input bit assert_rst);
        @(posedge clk);
        cycle++;
        if (rst) model_reset();
        else     model_edge();
        if (assert_rst) begin
            #1;
            rst = 1'b1;
            model_reset();
        end
        push_expected();
        #1;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step(1'b0);
    endtask

    task automatic run_until(input int want_duty, input bit want_idle, input int bound);
        int k;
        k = 0;
        while (!(want_idle ? (m_mode == "IDLE") : (m_duty == want_duty)) && k < bound) begin
            step(1'b0);
            k++;
        end
        if (k >= bound) begin
            vectors++;
            miscompares++;
            $display("FAIL timeout in %s: model never reached duty=%0d idle=%0b within %0d cycles",
                     phase_name, want_duty, want_idle, bound);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            vectors++;
            if (int'(o_duty) != e.duty || o_en !== e.en || o_ramping !== e.ramp || o_done !== e.done) begin
                miscompares++;
                $display("FAIL %s cycle %0d: got duty=%0d en=%b ramping=%b done=%b, expected duty=%0d en=%0b ramping=%0b done=%0b",
                         e.tag, cycle, o_duty, o_en, o_ramping, o_done, e.duty, e.en, e.ramp, e.done);
            end
        end
    end

    initial begin
        model_reset();
        run(3);
        rst = 1'b0;
        run(5);

        phase_name = "startup_ramp";
        i_target = 8'd100;
        enable   = 1'b1;
        run(410);

        phase_name = "track_down";
        i_target = 8'd90;
        run(60);
        i_target = 8'd100;
        run(60);

        phase_name = "disable_reenable";
        enable = 1'b0;
        run_until(60, 1'b0, 1000);
        enable = 1'b1;
        run(200);
        enable = 1'b0;
        run_until(0, 1'b1, 1000);
        run(6);

        phase_name = "clamp";
        i_target = 8'd255;
        enable   = 1'b1;
        run(950);
        enable = 1'b0;
        run_until(0, 1'b1, 2000);
        run(4);

        phase_name = "reset_mid_ramp";
        enable = 1'b1;
        run_until(37, 1'b0, 1000);
        step(1'b1);
        enable = 1'b0;
        run(3);
        rst = 1'b0;
        run(10);

        phase_name = "zero_target";
        i_target = 8'd0;
        enable   = 1'b1;
        run(8);
        enable = 1'b0;
        run(8);

        phase_name = "random";
        for (int it = 0; it < 40; it++) begin
            enable   = ($urandom_range(0, 3) != 0);
            i_target = ($urandom_range(0, 1) == 0) ? DW'($urandom_range(0, 255))
                                                  : DW'($urandom_range(0, 12));
            run($urandom_range(1, 250));
        end

        phase_name = "final_off";
        enable = 1'b0;
        run_until(0, 1'b1, 2000);
        run(4);

        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
